// File: rtl/seq_alu.sv
// ----------------------------------------------------------------------------
// seq_alu
//
// Handshaked ALU between the register-file read stage and the writeback /
// memory-address stage. ADD, SUB, LOAD and STR finish in one cycle. MUL uses
// shift-add and DIV/MOD use restoring division, both one bit per cycle, so the
// control unit stalls on in_ready / out_valid.
//
// Ports
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_valid / in_ready   request handshake; opcode, a, b are latched on accept
//   opcode                000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 LOAD,
//                         101 STR, 110 MOD, 111 reserved
//   a, b                  unsigned operands (dividend/multiplicand, divisor/multiplier)
//   out_valid / out_ready result handshake; result and flags hold while out_valid
//   result                WIDTH-bit result
//   flag_zero             result == 0
//   flag_carry            ADD/LOAD/STR carry-out, SUB borrow
//   flag_ovf              ADD/SUB signed overflow, MUL high product half non-zero
//   flag_dz               DIV/MOD by zero
// ----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_dz
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_DIV  = 3'b011,
        OP_LOAD = 3'b100,
        OP_STR  = 3'b101,
        OP_MOD  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e             state, state_nxt;
    logic               in_ready_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;      // multiply accumulator
    logic [2*WIDTH-1:0] mcand;    // multiplicand, shifted left one place per step
    logic [WIDTH-1:0]   mplier;   // multiplier, shifted right one place per step
    logic [WIDTH-1:0]   rem;      // partial remainder
    logic [WIDTH-1:0]   quo;      // dividend shifting out MSB-first, quotient shifting in
    logic [WIDTH-1:0]   divisor;
    logic               is_mod;

    op_e  op;
    logic accept;
    logic last_step;

    assign op        = op_e'(opcode);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q;
    assign last_step = (cnt == CNT_W'(1));

    // Single-cycle arithmetic on the live inputs; only used on the accept edge.
    logic [WIDTH:0] sum, diff;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};   // diff[WIDTH] is the borrow (a < b)

    // One iteration of shift-add multiply and restoring divide.
    logic [2*WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH:0]     div_trial, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_nxt, quo_nxt;

    always_comb begin
        mul_acc_nxt = mplier[0] ? (acc + mcand) : acc;
        div_trial   = {rem, quo[WIDTH-1]};
        div_diff    = div_trial - {1'b0, divisor};
        // rem < divisor keeps div_trial below 2*divisor, so the top bit of the
        // difference is a clean "trial < divisor" indicator.
        div_ge      = ~div_diff[WIDTH];
        rem_nxt     = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
        quo_nxt     = {quo[WIDTH-2:0], div_ge};
    end

    // Result/flag load: the output registers change only when entering DONE.
    logic             res_we;
    logic [WIDTH-1:0] res_d;
    logic             carry_d, ovf_d, dz_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statements can leave one unassigned (no latches).
        res_we  = 1'b0;
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        dz_d    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_ADD, OP_LOAD, OP_STR: begin
                            res_we  = 1'b1;
                            res_d   = sum[WIDTH-1:0];
                            carry_d = sum[WIDTH];
                            ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SUB: begin
                            res_we  = 1'b1;
                            res_d   = diff[WIDTH-1:0];
                            carry_d = diff[WIDTH];
                            ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_DIV, OP_MOD: begin
                            if (b == '0) begin
                                res_we = 1'b1;
                                dz_d   = 1'b1;
                            end
                        end
                        OP_RSVD: res_we = 1'b1;
                        default: ;   // OP_MUL starts iterating
                    endcase
                end
            end
            S_MUL: begin
                if (last_step) begin
                    res_we = 1'b1;
                    res_d  = mul_acc_nxt[WIDTH-1:0];
                    ovf_d  = |mul_acc_nxt[2*WIDTH-1:WIDTH];
                end
            end
            S_DIV: begin
                if (last_step) begin
                    res_we = 1'b1;
                    res_d  = is_mod ? rem_nxt : quo_nxt;
                end
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of its inputs.
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MUL:         state_nxt = S_MUL;
                        OP_DIV, OP_MOD: state_nxt = (b == '0) ? S_DONE : S_DIV;
                        default:        state_nxt = S_DONE;
                    endcase
                end
            end
            S_MUL:   if (last_step) state_nxt = S_DONE;
            S_DIV:   if (last_step) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        out_valid = (state == S_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset as well, so an aborted
            // operation leaves nothing stale behind in the result or flags.
            in_ready_q <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
            is_mod     <= 1'b0;
            result     <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            flag_dz    <= 1'b0;
        end else begin
            // Registered so in_ready stays low through reset and rises on the
            // first edge after rst_n is released.
            in_ready_q <= (state_nxt == S_IDLE);

            if (res_we) begin
                result     <= res_d;
                flag_zero  <= (res_d == '0);
                flag_carry <= carry_d;
                flag_ovf   <= ovf_d;
                flag_dz    <= dz_d;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt     <= CNT_W'(WIDTH);
                        acc     <= '0;
                        mcand   <= {{WIDTH{1'b0}}, a};
                        mplier  <= b;
                        rem     <= '0;
                        quo     <= a;
                        divisor <= b;
                        is_mod  <= (op == OP_MOD);
                    end
                end
                S_MUL: begin
                    acc    <= mul_acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                end
                S_DIV: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// ----------------------------------------------------------------------------
// tb_seq_alu
//
// Directed bench for seq_alu (WIDTH=16). Each scenario task drives its own
// vectors and compares latency, result/flags and handshake state against
// hand-computed values. Outputs are sampled 1 time unit after a rising edge.
// ----------------------------------------------------------------------------
module tb_seq_alu;

    localparam int W = 16;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_STR  = 3'b101;
    localparam logic [2:0] OP_MOD  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [2:0]   opcode    = 3'b000;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] result;
    logic         flag_zero, flag_carry, flag_ovf, flag_dz;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf),
        .flag_dz    (flag_dz)
    );

    // Result and flags packed as {result, zero, carry, ovf, dz}.
    logic [W+3:0] status;
    assign status = {result, flag_zero, flag_carry, flag_ovf, flag_dz};

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W+3:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] va,
                                input logic [W-1:0] vb, input logic [W-1:0] res,
                                input logic z, input logic c, input logic o, input logic d);
        vec_t v;
        v.op  = op;
        v.va  = va;
        v.vb  = vb;
        v.exp = {res, z, c, o, d};
        return v;
    endfunction

    // Waits (bounded) for in_ready, presents one request for exactly one
    // accept edge, then scrambles the inputs to show they were latched.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] ia, input logic [W-1:0] ib);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_in_ready: in_ready=%b required=1", in_ready);
        end
        opcode   = op;
        a        = ia;
        b        = ib;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode   = OP_RSVD;
        a        = ~ia;
        b        = ~ib;
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_handshake: in_ready,out_valid=%b required=00", {in_ready, out_valid});
        end
        n_checks++;
        if (status !== '0) begin
            n_fail++;
            $display("FAIL reset_status: status=%h required=0", status);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: in_ready,out_valid=%b required=10", {in_ready, out_valid});
        end
    endtask

    task automatic test_single_cycle();
        vec_t v[9];
        int   lat;
        v[0] = mk(OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
        v[1] = mk(OP_LOAD, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        v[2] = mk(OP_STR,  16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        v[3] = mk(OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0);
        v[4] = mk(OP_SUB,  16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        v[5] = mk(OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0);
        v[6] = mk(OP_RSVD, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        v[7] = mk(OP_DIV,  16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        v[8] = mk(OP_MOD,  16'h0009, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            issue(v[i].op, v[i].va, v[i].vb);
            wait_out(lat);
            n_checks++;
            if (lat !== 0) begin
                n_fail++;
                $display("FAIL single_latency[%0d]: edges=%0d required=0", i, lat);
            end
            n_checks++;
            if (status !== v[i].exp) begin
                n_fail++;
                $display("FAIL single_status[%0d] op=%b: status=%h required=%h", i, v[i].op, status, v[i].exp);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL single_idle[%0d]: out_valid,in_ready=%b required=01", i, {out_valid, in_ready});
            end
        end
    endtask

    task automatic test_iterative();
        vec_t v[10];
        int   lat;
        v[0] = mk(OP_MUL, 16'h0100, 16'h0101, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b0);
        v[1] = mk(OP_MUL, 16'h00FF, 16'h0002, 16'h01FE, 1'b0, 1'b0, 1'b0, 1'b0);
        v[2] = mk(OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
        v[3] = mk(OP_MUL, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        v[4] = mk(OP_DIV, 16'd1000, 16'd7,    16'd142,  1'b0, 1'b0, 1'b0, 1'b0);
        v[5] = mk(OP_MOD, 16'd1000, 16'd7,    16'd6,    1'b0, 1'b0, 1'b0, 1'b0);
        v[6] = mk(OP_DIV, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        v[7] = mk(OP_MOD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        v[8] = mk(OP_DIV, 16'd3,    16'd10,   16'd0,    1'b1, 1'b0, 1'b0, 1'b0);
        v[9] = mk(OP_MOD, 16'd3,    16'd10,   16'd3,    1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            issue(v[i].op, v[i].va, v[i].vb);
            wait_out(lat);
            n_checks++;
            if (lat !== W) begin
                n_fail++;
                $display("FAIL iter_latency[%0d]: edges=%0d required=%0d", i, lat, W);
            end
            n_checks++;
            if (status !== v[i].exp) begin
                n_fail++;
                $display("FAIL iter_status[%0d] op=%b: status=%h required=%h", i, v[i].op, status, v[i].exp);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL iter_idle[%0d]: out_valid,in_ready=%b required=01", i, {out_valid, in_ready});
            end
        end
    endtask

    task automatic test_backpressure();
        int           lat;
        logic [W+3:0] exp_st;
        exp_st    = {16'h0030, 1'b0, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b0;
        issue(OP_ADD, 16'h0010, 16'h0020);
        wait_out(lat);
        n_checks++;
        if (lat !== 0) begin
            n_fail++;
            $display("FAIL bp_latency: edges=%0d required=0", lat);
        end
        // A competing request is presented while the result is stalled.
        opcode   = OP_SUB;
        a        = 16'h0001;
        b        = 16'h0002;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, in_ready} !== 2'b10) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: out_valid,in_ready=%b required=10", i, {out_valid, in_ready});
            end
            n_checks++;
            if (status !== exp_st) begin
                n_fail++;
                $display("FAIL bp_stable[%0d]: status=%h required=%h", i, status, exp_st);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: out_valid,in_ready=%b required=01", {out_valid, in_ready});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, status} !== {1'b0, exp_st}) begin
            n_fail++;
            $display("FAIL bp_not_queued: out_valid,status=%h required=%h", {out_valid, status}, {1'b0, exp_st});
        end
    endtask

    task automatic test_reset_mid_op();
        int pulses = 0;
        int lat;
        out_ready = 1'b1;
        issue(OP_DIV, 16'd1000, 16'd7);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;            // reset sampled on the 8th iteration edge
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, in_ready, status} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: out_valid,in_ready,status=%h required=0", {out_valid, in_ready, status});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL midrst_no_result: out_valid pulses=%0d required=0", pulses);
        end
        n_checks++;
        if ({in_ready, status} !== {1'b1, 20'h0}) begin
            n_fail++;
            $display("FAIL midrst_idle: in_ready,status=%h required=%h", {in_ready, status}, {1'b1, 20'h0});
        end
        issue(OP_ADD, 16'd2, 16'd3);
        wait_out(lat);
        n_checks++;
        if (lat !== 0) begin
            n_fail++;
            $display("FAIL midrst_add_latency: edges=%0d required=0", lat);
        end
        n_checks++;
        if (status !== {16'd5, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL midrst_add_status: status=%h required=%h", status, {16'd5, 4'b0000});
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_iterative();
        test_backpressure();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
